// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host-command master.
package wb_host_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Wide enough for the largest legal timeout (65535 cycles).
  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Response payload: read data only for an acknowledged read, zero for
  // writes and for timeouts.
  function automatic logic [WB_DAT_W-1:0] rsp_data(
    input logic                acked,
    input logic                is_write,
    input logic [WB_DAT_W-1:0] bus_dat
  );
    return (acked && !is_write) ? bus_dat : '0;
  endfunction

endpackage

// File: rtl/wb_host_timer.sv
// Bus-cycle timeout counter: cleared when a command is accepted, counts every
// cycle it is enabled, and flags the cycle in which the TIMEOUT_CYCLES-th
// enabled cycle is reached.
module wb_host_timer
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  // Count holds the number of completed enabled cycles, so the current cycle
  // is number count+1; it is the last permitted one at count == TIMEOUT-1.
  assign expired = enable && (count >= TIMER_W'(TIMEOUT_CYCLES - 1));

  // Cycle counter; stops once expired so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic master driven by a valid/ready command
// port, returning read data or a timeout error on a valid/ready response port.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,

  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,

  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,

  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i,

  output logic                busy_o
);

  state_e state;
  state_e next_state;

  logic accept;
  logic ack_seen;
  logic timed_out;
  logic rsp_done;
  logic expired;
  logic in_bus;

  assign in_bus = (state == BUS);

  wb_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (accept),
    .enable (in_bus),
    .expired(expired)
  );

  // Next-state decode and the handshake/termination events of this cycle.
  // Ack is tested before the timer so an ack in the timeout cycle wins.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    next_state = state;
    accept     = 1'b0;
    ack_seen   = 1'b0;
    timed_out  = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          accept     = 1'b1;
          next_state = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          ack_seen   = 1'b1;
          next_state = RESP;
        end else if (expired) begin
          timed_out  = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered outputs: handshake flags follow the next state, bus fields are
  // latched on acceptance and held afterwards, response is captured on ack or
  // timeout and held until consumed.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      cmd_ready_o <= (next_state == IDLE);
      busy_o      <= (next_state != IDLE);

      if (accept) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= cmd_we_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
        wbm_sel_o <= cmd_sel_i;
      end

      if (ack_seen || timed_out) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= timed_out;
        rsp_dat_o   <= rsp_data(ack_seen, wbm_we_o, wbm_dat_i);
      end

      if (rsp_done) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: directed command sequences, a
// transaction-level scoreboard compared every cycle, and a second instance
// with a short timeout for the ack-versus-timeout boundary.
module tb_wb_host_master;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack, busy;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;

  wb_host_master #(.TIMEOUT_CYCLES(TO)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(wdat), .wbm_sel_o(sel), .wbm_dat_i(rdat), .wbm_ack_i(ack),
    .busy_o(busy)
  );

  // Second instance with a 4-cycle timeout, driven only by the c4_* signals.
  logic        c4_valid, c4_ready, c4_rsp_valid, c4_rsp_err, c4_cyc, c4_stb;
  logic        c4_we_o, c4_ack, c4_busy;
  logic        c4_we = 1'b0;
  logic        c4_rsp_ready = 1'b1;
  logic [31:0] c4_adr, c4_rsp_dat, c4_adr_o, c4_dat_o, c4_rdat;
  logic [31:0] c4_dat = 32'h0;
  logic [3:0]  c4_sel = 4'hF;
  logic [3:0]  c4_sel_o;

  wb_host_master #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(c4_valid), .cmd_ready_o(c4_ready), .cmd_we_i(c4_we),
    .cmd_adr_i(c4_adr), .cmd_dat_i(c4_dat), .cmd_sel_i(c4_sel),
    .rsp_valid_o(c4_rsp_valid), .rsp_ready_i(c4_rsp_ready),
    .rsp_dat_o(c4_rsp_dat), .rsp_err_o(c4_rsp_err),
    .wbm_cyc_o(c4_cyc), .wbm_stb_o(c4_stb), .wbm_we_o(c4_we_o),
    .wbm_adr_o(c4_adr_o), .wbm_dat_o(c4_dat_o), .wbm_sel_o(c4_sel_o),
    .wbm_dat_i(c4_rdat), .wbm_ack_i(c4_ack), .busy_o(c4_busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // Slave model: acks on the ack_delay-th bus cycle (-1 = never); outside a
  // bus cycle it drives stray_ack so ignored acks can be injected.
  int          ack_delay = -1;
  logic [31:0] ack_data  = 32'h0;
  logic        stray_ack = 1'b0;
  int          bus_n     = 0;

  initial begin : slave
    ack  = 1'b0;
    rdat = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (cyc) begin
        bus_n++;
        ack = (bus_n == ack_delay);
      end else begin
        bus_n = 0;
        ack   = stray_ack;
      end
      rdat = ack ? ack_data : 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: tracks the outstanding transaction from the observed
  // handshakes and checks every output every cycle.
  bit          m_bus = 0, m_rsp = 0, prev_rst = 1;
  logic        m_we = 1'b0;
  logic [31:0] m_adr = 32'h0, m_dat = 32'h0;
  logic [3:0]  m_sel = 4'h0;
  int          m_n = 0;
  logic [31:0] e_dat = 32'h0;
  logic        e_err = 1'b0;

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        check("rst_ctrl", 32'({cmd_ready, busy, cyc, stb, we, rsp_valid, rsp_err}), 32'h0);
        check("rst_adr", adr, 32'h0);
        check("rst_wdat", wdat, 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
      end else begin
        // Field values always equal the last accepted command (zero after reset).
        check_bit("hold_we", we, m_we);
        check("hold_adr", adr, m_adr);
        check("hold_sel", 32'(sel), 32'(m_sel));
        if (m_we) check("hold_wdat", wdat, m_dat);
        if (m_bus) begin
          check("bus_ctrl", 32'({cmd_ready, busy, cyc, stb, rsp_valid}), 32'b01110);
          m_n++;
          if (ack) begin
            m_bus = 0; m_rsp = 1; e_err = 1'b0;
            e_dat = m_we ? 32'h0 : rdat;
          end else if (m_n == TO) begin
            m_bus = 0; m_rsp = 1; e_err = 1'b1; e_dat = 32'h0;
          end
        end else if (m_rsp) begin
          check("rsp_ctrl", 32'({cmd_ready, busy, cyc, stb, rsp_valid}), 32'b01001);
          check("rsp_dat", rsp_dat, e_dat);
          check_bit("rsp_err", rsp_err, e_err);
          if (rsp_ready) m_rsp = 0;
        end else begin
          check("idle_ctrl", 32'({cmd_ready, busy, cyc, stb, rsp_valid}), 32'b10000);
          if (cmd_valid) begin
            m_bus = 1; m_n = 0;
            m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat; m_sel = cmd_sel;
          end
        end
      end
      if (rst) begin
        m_bus = 0; m_rsp = 0; m_we = 1'b0; m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0;
      end
      prev_rst = rst;
    end
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int acc);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc_no;
        break;
      end
    end
    check_bit("cmd_accepted", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc_no;
        break;
      end
    end
    check_bit("rsp_seen", rsp_valid, 1'b1);
  endtask

  task automatic c4_run(input int ack_at, input logic [31:0] adr_v, output int n);
    c4_adr = adr_v; c4_valid = 1'b1; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c4_ready) break;
    end
    check_bit("c4_accepted", c4_ready, 1'b1);
    @(posedge clk);
    #1;
    c4_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (c4_cyc) begin
        n++;
        c4_ack = (n == ack_at);
      end else begin
        c4_ack = 1'b0;
      end
      c4_rdat = c4_ack ? 32'h0BAD_F00D : 32'h0;
      @(negedge clk);
      if (c4_rsp_valid) break;
      @(posedge clk);
      #1;
    end
    check_bit("c4_rsp_seen", c4_rsp_valid, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acc, acc2, at, h, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; rsp_ready = 1'b1;
    c4_valid = 1'b0; c4_adr = 32'h0; c4_ack = 1'b0; c4_rdat = 32'h0;

    // Reset: ready low during reset, high the cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("ready_in_reset", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_bit("ready_after_release", cmd_ready, 1'b1);
    check_bit("busy_after_release", busy, 1'b0);
    @(posedge clk);
    #1;

    // Write, ack on the 2nd bus cycle.
    ack_delay = 2;
    send_cmd(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, acc);
    @(negedge clk);
    check_bit("wr_cyc", cyc, 1'b1);
    check_bit("wr_we", we, 1'b1);
    check("wr_adr", adr, 32'h3000_0004);
    check("wr_dat", wdat, 32'hA5A5_5A5A);
    check("wr_sel", 32'(sel), 32'hF);
    wait_rsp(at);
    check("wr_latency", at - acc, 3);
    check_bit("wr_rsp_err", rsp_err, 1'b0);
    check("wr_rsp_dat", rsp_dat, 32'h0);
    @(posedge clk);
    #1;

    // Read, immediate ack: response two cycles after acceptance.
    ack_delay = 1; ack_data = 32'h1234_5678;
    send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, acc);
    wait_rsp(at);
    check("rd_latency", at - acc, 2);
    check("rd_rsp_dat", rsp_dat, 32'h1234_5678);
    check_bit("rd_rsp_err", rsp_err, 1'b0);
    @(posedge clk);
    #1;

    // Timeout: no ack, cyc high exactly TO cycles.
    ack_delay = -1;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h3, acc);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (cyc) n++;
    end
    check("to_cyc_cycles", n, 8);
    check_bit("to_rsp_valid", rsp_valid, 1'b1);
    check_bit("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_dat", rsp_dat, 32'h0);
    @(posedge clk);
    #1;

    // Ack on the timeout cycle itself: the ack wins.
    ack_delay = 8; ack_data = 32'h0F0F_1234;
    send_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, acc);
    wait_rsp(at);
    check("edge_latency", at - acc, 9);
    check_bit("edge_rsp_err", rsp_err, 1'b0);
    check("edge_rsp_dat", rsp_dat, 32'h0F0F_1234);
    @(posedge clk);
    #1;

    // Response back-pressure with a second command waiting.
    rsp_ready = 1'b0; ack_delay = 1; ack_data = 32'hCAFE_F00D;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, acc);
    cmd_we = 1'b1; cmd_adr = 32'h3000_0014; cmd_dat = 32'h1122_3344; cmd_sel = 4'hC;
    cmd_valid = 1'b1;
    wait_rsp(at);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check_bit("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
      check_bit("bp_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    h = cyc_no;
    acc2 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc2 = cyc_no;
        break;
      end
    end
    check("bp_second_accept", acc2 - h, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp(at);
    check("bp_second_rsp_dat", rsp_dat, 32'h0);
    @(posedge clk);
    #1;

    // Back-to-back: one transaction per three cycles.
    ack_delay = 1; ack_data = 32'h5555_AAAA;
    send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, acc);
    send_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF, acc2);
    check("b2b_spacing", acc2 - acc, 3);
    wait_rsp(at);
    @(posedge clk);
    #1;

    // Stray acks while idle are ignored.
    stray_ack = 1'b1; ack_data = 32'h7777_7777;
    repeat (3) begin
      @(negedge clk);
      check_bit("stray_idle_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    stray_ack = 1'b0;

    // Reset during the 3rd bus cycle, then a late ack.
    ack_delay = -1;
    send_cmd(1'b1, 32'h3000_0030, 32'h9999_0000, 4'h1, acc);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rstbus_cycle", bus_n, 3);
    check_bit("rstbus_cyc_before", cyc, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_bit("rstbus_cyc", cyc, 1'b0);
    check_bit("rstbus_stb", stb, 1'b0);
    check_bit("rstbus_rsp_valid", rsp_valid, 1'b0);
    stray_ack = 1'b1; ack_data = 32'h1357_9BDF;
    repeat (4) begin
      @(negedge clk);
      check_bit("late_ack_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    stray_ack = 1'b0;

    // Reset while a response is pending discards it.
    rsp_ready = 1'b0; ack_delay = 1; ack_data = 32'h2468_ACE0;
    send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, acc);
    wait_rsp(at);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; rsp_ready = 1'b1;
    check_bit("rstrsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_bit("rstrsp_ready_back", cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // Four-cycle timeout instance: ack on the 4th cycle wins, no ack times out.
    c4_run(4, 32'h3000_0050, n);
    check("c4_ack_cycles", n, 4);
    check_bit("c4_ack_err", c4_rsp_err, 1'b0);
    check("c4_ack_dat", c4_rsp_dat, 32'h0BAD_F00D);
    @(posedge clk);
    #1;
    c4_run(-1, 32'h3000_0054, n);
    check("c4_to_cycles", n, 4);
    check_bit("c4_to_err", c4_rsp_err, 1'b1);
    check("c4_to_dat", c4_rsp_dat, 32'h0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
